// File: rtl/rc4_pkg.sv
// Shared constants and state encoding for the RC4 key-search front end.
package rc4_pkg;

    localparam int KEY_W          = 24;
    localparam int KEY_SPACE_BITS = 22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } dispatch_state_t;

endpackage

// File: rtl/lowest_one_picker.sv
// Priority encoder: index of the lowest set request bit, plus an any-set flag.
module lowest_one_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_space_dispatcher.sv
// Splits the key space across NUM_CORES cracking cores, launches them and keeps the first key found.
// Handshake: core_done[i] is a one-cycle pulse; core_found[i]/core_key are only meaningful with it.
module key_space_dispatcher #(
    parameter int NUM_CORES      = 4,
    parameter int KEY_W          = rc4_pkg::KEY_W,
    parameter int KEY_SPACE_BITS = rc4_pkg::KEY_SPACE_BITS,
    localparam int IDX_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES*KEY_W-1:0]   core_key_first,
    output logic [NUM_CORES*KEY_W-1:0]   core_key_last,
    output logic                         core_abort,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES-1:0]         core_found,
    input  logic [NUM_CORES*KEY_W-1:0]   core_key,
    output logic                         busy,
    output logic                         found,
    output logic                         exhausted,
    output logic [KEY_W-1:0]             found_key,
    output logic [IDX_W-1:0]             found_core,
    output rc4_pkg::dispatch_state_t     dbg_state
);

    import rc4_pkg::*;

    localparam longint SPAN = (longint'(1) << KEY_SPACE_BITS) / NUM_CORES;

    logic [KEY_W-1:0] key_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_range
        assign core_key_first[g*KEY_W +: KEY_W] = KEY_W'(longint'(g) * SPAN);
        assign core_key_last[g*KEY_W +: KEY_W]  = KEY_W'((longint'(g) + 1) * SPAN - 1);
        assign key_arr[g] = core_key[g*KEY_W +: KEY_W];
    end

    dispatch_state_t        state_q, state_d;
    logic [NUM_CORES-1:0]   done_q, done_d;
    logic                   found_q, found_d;
    logic                   exhausted_q, exhausted_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic [IDX_W-1:0]       core_q, core_d;
    logic                   restart_q, restart_d;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;

    lowest_one_picker #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (core_done & core_found),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        key_d       = key_q;
        core_d      = core_q;
        restart_d   = 1'b0;
        core_start  = '0;
        core_abort  = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || restart_q) begin
                    state_d     = ST_LAUNCH;
                    done_d      = '0;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    key_d       = '0;
                    core_d      = '0;
                end
            end
            ST_LAUNCH: begin
                busy       = 1'b1;
                core_start = '1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                busy   = 1'b1;
                done_d = done_q | core_done;
                if (win_valid) begin
                    found_d = 1'b1;
                    key_d   = key_arr[win_idx];
                    core_d  = win_idx;
                    state_d = ST_DRAIN;
                end else if (&done_d) begin
                    exhausted_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DRAIN: begin
                // Late finds are ignored; only completion of every core matters here.
                busy       = 1'b1;
                core_abort = 1'b1;
                done_d     = done_q | core_done;
                if (&done_d) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    restart_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_q      <= '0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            key_q       <= '0;
            core_q      <= '0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
            key_q       <= key_d;
            core_q      <= core_d;
            restart_q   <= restart_d;
        end
    end

    assign found      = found_q;
    assign exhausted  = exhausted_q;
    assign found_key  = key_q;
    assign found_core = core_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_key_space_dispatcher.sv
// Bench for key_space_dispatcher: directed scenarios plus randomized searches against a search-outcome model.
module tb_key_space_dispatcher;
    import rc4_pkg::*;

    localparam int NC = 4;
    localparam int KW = 24;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [NC-1:0]        core_start;
    logic [NC*KW-1:0]     core_key_first;
    logic [NC*KW-1:0]     core_key_last;
    logic                 core_abort;
    logic [NC-1:0]        core_done;
    logic [NC-1:0]        core_found;
    logic [NC*KW-1:0]     core_key;
    logic                 busy;
    logic                 found;
    logic                 exhausted;
    logic [KW-1:0]        found_key;
    logic [1:0]           found_core;
    dispatch_state_t      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-search core behaviour: cycle of done pulse, whether it finds, its key, reaction delay to abort.
    int           sched_dly  [NC];
    bit           sched_fnd  [NC];
    logic [KW-1:0] sched_key [NC];
    int           sched_adly [NC];

    key_space_dispatcher #(
        .NUM_CORES      (NC),
        .KEY_W          (KW),
        .KEY_SPACE_BITS (22)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .core_start     (core_start),
        .core_key_first (core_key_first),
        .core_key_last  (core_key_last),
        .core_abort     (core_abort),
        .core_done      (core_done),
        .core_found     (core_found),
        .core_key       (core_key),
        .busy           (busy),
        .found          (found),
        .exhausted      (exhausted),
        .found_key      (found_key),
        .found_core     (found_core),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_found"}, found, 1'b0);
        check({tag, "_exhausted"}, exhausted, 1'b0);
        check({tag, "_found_key"}, found_key, '0);
        check({tag, "_found_core"}, found_core, '0);
        check({tag, "_core_start"}, core_start, '0);
        check({tag, "_core_abort"}, core_abort, 1'b0);
    endtask

    task automatic pulse_start_and_launch(input string tag);
        int wait_n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n = 0;
        while (core_start == '0 && wait_n < 4) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_core_start"}, core_start, {NC{1'b1}});
        check({tag, "_busy_launch"}, busy, 1'b1);
        check({tag, "_flags_clear"}, {found, exhausted}, 2'b00);
    endtask

    // Runs one search using the sched_* arrays and compares the outcome with the model.
    task automatic run_search(input string tag);
        int  best;
        int  cyc;
        int  abort_cyc;
        int  extra_starts;
        bit  abort_seen;
        bit  both_flags;
        bit  done_v [NC];
        bit  all_done;
        logic [KW-1:0] exp_key;

        // Model: earliest finding core wins, ties to the lowest index; no finder means exhausted.
        best = -1;
        for (int i = 0; i < NC; i++) begin
            if (sched_fnd[i] && (best < 0 || sched_dly[i] < sched_dly[best])) best = i;
        end
        exp_key = (best >= 0) ? sched_key[best] : '0;

        pulse_start_and_launch(tag);
        for (int i = 0; i < NC; i++) done_v[i] = 1'b0;
        cyc = 0; abort_cyc = 0; extra_starts = 0;
        abort_seen = 1'b0; both_flags = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            core_done  = '0;
            core_found = '0;
            if (core_start != '0) extra_starts++;
            if (found && exhausted) both_flags = 1'b1;
            if (!busy) break;
            if (core_abort && !abort_seen) begin
                abort_seen = 1'b1;
                abort_cyc  = cyc;
            end
            for (int i = 0; i < NC; i++) begin
                core_key[i*KW +: KW] = sched_key[i];
                if (!done_v[i]) begin
                    if (abort_seen) begin
                        if (cyc >= abort_cyc + sched_adly[i]) begin
                            core_done[i] = 1'b1;
                            done_v[i]    = 1'b1;
                        end
                    end else if (cyc == sched_dly[i]) begin
                        core_done[i]  = 1'b1;
                        core_found[i] = sched_fnd[i];
                        done_v[i]     = 1'b1;
                    end
                end
            end
        end
        core_done  = '0;
        core_found = '0;
        all_done = 1'b1;
        for (int i = 0; i < NC; i++) all_done &= done_v[i];

        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_found"}, found, best >= 0);
        check({tag, "_exhausted"}, exhausted, best < 0);
        check({tag, "_found_key"}, found_key, exp_key);
        check({tag, "_found_core"}, found_core, (best >= 0) ? best : 0);
        check({tag, "_abort_seen"}, abort_seen, best >= 0);
        check({tag, "_abort_end"}, core_abort, 1'b0);
        check({tag, "_all_done_before_end"}, all_done, 1'b1);
        check({tag, "_single_core_start"}, extra_starts, 0);
        check({tag, "_flags_exclusive"}, both_flags, 1'b0);
    endtask

    task automatic set_core(input int i, input int dly, input bit fnd, input logic [KW-1:0] key,
                            input int adly);
        sched_dly[i]  = dly;
        sched_fnd[i]  = fnd;
        sched_key[i]  = key;
        sched_adly[i] = adly;
    endtask

    initial begin
        longint span;
        rst = 1'b1; start = 1'b0;
        core_done = '0; core_found = '0; core_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Ranges: equal contiguous slices of 2^22.
        span = (longint'(1) << 22) / NC;
        for (int i = 0; i < NC; i++) begin
            check($sformatf("range_first%0d", i), core_key_first[i*KW +: KW], KW'(i * span));
            check($sformatf("range_last%0d", i), core_key_last[i*KW +: KW], KW'((i + 1) * span - 1));
        end

        // Core 2 finds 2A1B3C; the others are aborted.
        set_core(0, 9, 1'b0, 24'h000111, 2);
        set_core(1, 10, 1'b0, 24'h100222, 0);
        set_core(2, 3, 1'b1, 24'h2A1B3C, 0);
        set_core(3, 11, 1'b0, 24'h300333, 3);
        run_search("find_core2");

        // Every core finishes without a key, each on a different cycle.
        set_core(0, 2, 1'b0, 24'h000001, 0);
        set_core(1, 5, 1'b0, 24'h100001, 0);
        set_core(2, 7, 1'b0, 24'h200001, 0);
        set_core(3, 9, 1'b0, 24'h300001, 0);
        run_search("exhaust");

        // Cores 1 and 3 find on the same cycle; core 1 must win.
        set_core(0, 8, 1'b0, 24'h000abc, 1);
        set_core(1, 4, 1'b1, 24'h123456, 0);
        set_core(2, 9, 1'b0, 24'h200abc, 2);
        set_core(3, 4, 1'b1, 24'h3FEDCB, 0);
        run_search("tie_1_3");

        // start during RUN is ignored, then reset mid-search returns to IDLE.
        pulse_start_and_launch("busy_start");
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("busy_start_no_relaunch%0d", k), core_start, '0);
            check($sformatf("busy_start_busy%0d", k), busy, 1'b1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        rst = 1'b0;

        // Randomized searches, each one launched from DONE (or IDLE after the reset above).
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NC; i++) begin
                set_core(i, $urandom_range(1, 12), ($urandom_range(0, 3) == 0),
                         KW'($urandom & 32'h003F_FFFF), $urandom_range(0, 3));
            end
            run_search($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
